uart_rx_deser: RTL and testbench



---
 rtl/uart_rx_deser.sv | 115 +++++++++++
 tb/tb_uart_rx_deser.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: recovers start/data/parity/stop frames from a synchronized
// RX line using an oversample tick, and emits one valid pulse per character with error flags.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level on a tick
// START  | counting to mid start bit to confirm it
// DATA   | sampling data bits at mid-bit, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, delivering the character
// BREAK  | line held low after a framing error, waiting for idle
module uart_rx_deser #(
  parameter int DataWidth = 8,
  parameter int OvsRate   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic                 tick_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  output logic                 rx_valid_o,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 busy_o
);

  localparam int OW = $clog2(OvsRate);
  localparam int BW = $clog2(DataWidth + 1);
  localparam logic [OW-1:0] HalfLast = OW'(OvsRate / 2 - 1);
  localparam logic [OW-1:0] FullLast = OW'(OvsRate - 1);
  localparam logic [BW-1:0] LastBit  = BW'(DataWidth - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t               state;
  logic [OW-1:0]        ovs_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DataWidth-1:0] shift;
  logic                 par_en;
  logic                 par_odd;
  logic                 par_err;
  logic                 sample_due;

  // The start bit is confirmed half a bit in; every later sample is a full bit apart.
  assign sample_due = (state == START) ? (ovs_cnt == HalfLast) : (ovs_cnt == FullLast);
  assign busy_o     = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ovs_cnt      <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      par_en       <= 1'b0;
      par_odd      <= 1'b0;
      par_err      <= 1'b0;
      rx_valid_o   <= 1'b0;
      rx_data_o    <= '0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      rx_valid_o   <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      if (tick_i) begin
        ovs_cnt <= sample_due ? '0 : ovs_cnt + OW'(1);
        case (state)
          IDLE: begin
            ovs_cnt <= '0;
            if (!rx_i) begin
              state   <= START;
              par_en  <= parity_en_i;
              par_odd <= parity_odd_i;
            end
          end
          START: begin
            if (sample_due) begin
              bit_cnt <= '0;
              state   <= rx_i ? IDLE : DATA;
            end
          end
          DATA: begin
            if (sample_due) begin
              shift   <= {rx_i, shift[DataWidth-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
              if (bit_cnt == LastBit) state <= par_en ? PARITY : STOP;
            end
          end
          PARITY: begin
            if (sample_due) begin
              par_err <= (^shift) ^ rx_i ^ par_odd;
              state   <= STOP;
            end
          end
          STOP: begin
            if (sample_due) begin
              rx_valid_o   <= 1'b1;
              rx_data_o    <= shift;
              frame_err_o  <= ~rx_i;
              parity_err_o <= par_en & par_err;
              state        <= rx_i ? IDLE : BREAK;
            end
          end
          BREAK: begin
            ovs_cnt <= '0;
            if (rx_i) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: table-driven frames, hand-written corner cases,
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx_deser;
  localparam int DW  = 8;
  localparam int OVS = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          tick = 1'b0;
  logic          par_en = 1'b0;
  logic          par_odd = 1'b0;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          frame_err;
  logic          parity_err;
  logic          busy;

  uart_rx_deser #(.DataWidth(DW), .OvsRate(OVS)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .tick_i      (tick),
    .parity_en_i (par_en),
    .parity_odd_i(par_odd),
    .rx_valid_o  (rx_valid),
    .rx_data_o   (rx_data),
    .frame_err_o (frame_err),
    .parity_err_o(parity_err),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] data; logic ferr; logic perr;} char_t;
  typedef struct {
    logic [7:0] d;
    logic pen, podd, pbit, stop;
    logic [7:0] exp_d;
    logic exp_f, exp_p;
  } vec_t;

  char_t got_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    tick_num = 0;
  int    last_valid_tick = 0;
  int    frame_start = 0;
  int    stray = 0;
  int    ph = 0;
  bit    rand_tick = 1'b0;
  logic  prev_valid = 1'b0;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  // Tick source: every 4th clock, or ~30% random duty.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_tick) tick = ($urandom_range(0, 99) < 30);
      else begin
        tick = (ph == 3);
        ph = (ph + 1) % 4;
      end
    end
  end

  always @(posedge clk) if (tick) tick_num <= tick_num + 1;

  // Capture characters; a flag outside a valid cycle or a 2-cycle valid is a stray.
  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back({rx_data, frame_err, parity_err});
      last_valid_tick = tick_num;
      if (prev_valid) stray++;
    end else if (frame_err || parity_err) stray++;
    prev_valid = rx_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      do begin
        @(posedge clk);
        guard++;
      end while (!tick && guard < 1000);
      if (guard >= 1000) begin
        $display("FAIL tick_timeout: actual=no tick required=tick within 1000 clocks");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
      end
      #1;
    end
  endtask

  // Reference model: a whole character from the frame contents.
  function automatic char_t model(input logic [7:0] d, input logic pen, input logic podd,
                                  input logic pbit, input logic stop);
    char_t c;
    int ones;
    ones   = $countones(d) + int'(pbit);
    c.data = d;
    c.ferr = !stop;
    c.perr = pen && ((ones % 2) != int'(podd));
    return c;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop, input int stop_len, input bit scramble);
    logic sv_en, sv_odd;
    sv_en  = par_en;
    sv_odd = par_odd;
    rx = 1'b0;
    frame_start = tick_num;
    wait_ticks(1);
    if (scramble) begin
      par_en  = 1'($urandom_range(0, 1));
      par_odd = 1'($urandom_range(0, 1));
    end
    wait_ticks(OVS - 1);
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      wait_ticks(OVS);
    end
    if (pen) begin
      rx = pbit;
      wait_ticks(OVS);
    end
    par_en  = sv_en;
    par_odd = sv_odd;
    rx = stop;
    wait_ticks(stop_len);
  endtask

  task automatic check_frame(input string name, input logic [7:0] ed, input logic ef,
                             input logic ep);
    char_t g;
    check({name, "_count"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      check({name, "_data"}, g.data, ed);
      check({name, "_ferr"}, g.ferr, ef);
      check({name, "_perr"}, g.perr, ep);
    end
    got_q.delete();
  endtask

  initial begin
    vec_t  vecs[8];
    char_t c, e;
    logic [7:0] rd;
    logic rpen, rpodd, rpbit, rstop;
    logic [7:0] seq6[3];

    vecs[0] = '{8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b1};
    vecs[1] = '{8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0};
    vecs[2] = '{8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0};
    vecs[3] = '{8'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1};
    vecs[4] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[5] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0};
    vecs[7] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1};
    seq6[0] = 8'h00;
    seq6[1] = 8'hFF;
    seq6[2] = 8'h81;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    wait_ticks(4);

    // Basic frame, no parity, latency from the start edge.
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    check("t1_latency", last_valid_tick - frame_start - 1, 152);
    check_frame("t1", 8'h55, 1'b0, 1'b0);
    check("t1_busy", busy, 0);

    foreach (vecs[i]) begin
      par_en  = vecs[i].pen;
      par_odd = vecs[i].podd;
      send_frame(vecs[i].d, vecs[i].pen, vecs[i].pbit, vecs[i].stop, 16, 1'b0);
      if (!vecs[i].stop) wait_ticks(20);
      rx = 1'b1;
      wait_ticks(4);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_f, vecs[i].exp_p);
    end
    par_en  = 1'b0;
    par_odd = 1'b0;

    // False start.
    check("t3_busy_pre", busy, 0);
    rx = 1'b0;
    wait_ticks(1);
    check("t3_busy_t0", busy, 1);
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(4);
    check("t3_busy_t7", busy, 1);
    wait_ticks(1);
    check("t3_busy_t8", busy, 0);
    wait_ticks(20);
    check("t3_no_valid", got_q.size(), 0);

    // Framing error followed by a held-low break, then a good character.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 16, 1'b0);
    wait_ticks(60);
    rx = 1'b1;
    wait_ticks(16);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    check("t4_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      c = got_q.pop_front();
      check("t4_a_data", c.data, 8'h3C);
      check("t4_a_ferr", c.ferr, 1);
      check("t4_a_perr", c.perr, 0);
      c = got_q.pop_front();
      check("t4_b_data", c.data, 8'h0F);
      check("t4_b_ferr", c.ferr, 0);
      check("t4_b_perr", c.perr, 0);
    end
    got_q.delete();

    // Reset during data bit 4 of 0x99.
    rx = 1'b0;
    wait_ticks(OVS);
    for (int i = 0; i < 4; i++) begin
      rx = seq6[0][0] | (8'h99 >> i) & 1'b1;
      wait_ticks(OVS);
    end
    rx = 1'b1;
    wait_ticks(8);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t5_busy", busy, 0);
    check("t5_data", rx_data, 0);
    check("t5_valid", rx_valid, 0);
    check("t5_ferr", frame_err, 0);
    check("t5_perr", parity_err, 0);
    rst = 1'b0;
    wait_ticks(20);
    check("t5_no_valid", got_q.size(), 0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    check_frame("t5_after", 8'hC3, 1'b0, 1'b0);

    // Random tick duty, back-to-back frames with a minimal stop bit, flags toggled mid-frame.
    rand_tick = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(seq6[i], 1'b0, 1'b0, 1'b1, OVS / 2 + 1, 1'b1);
    rx = 1'b1;
    wait_ticks(20);
    check("t6_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        c = got_q.pop_front();
        check($sformatf("t6_%0d_data", i), c.data, seq6[i]);
        check($sformatf("t6_%0d_err", i), {c.ferr, c.perr}, 2'b00);
      end
    end
    got_q.delete();

    // Randomized frames against the reference model.
    for (int n = 0; n < 12; n++) begin
      rd    = 8'($urandom);
      rpen  = 1'($urandom_range(0, 1));
      rpodd = 1'($urandom_range(0, 1));
      rpbit = 1'($urandom_range(0, 1));
      rstop = ($urandom_range(0, 3) != 0);
      par_en  = rpen;
      par_odd = rpodd;
      e = model(rd, rpen, rpodd, rpbit, rstop);
      send_frame(rd, rpen, rpbit, rstop, rstop ? int'($urandom_range(9, 20)) : 16, 1'b1);
      if (!rstop) wait_ticks(int'($urandom_range(0, 30)));
      rx = 1'b1;
      wait_ticks(int'($urandom_range(1, 10)));
      check_frame($sformatf("rnd%0d", n), e.data, e.ferr, e.perr);
    end

    check("stray_flags", stray, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
